// File: rtl/dice_pkg.sv
// Types and helpers shared by the die datapath and the game controller.
// Holds the roll state encoding, the face type and the LFSR tap mask.
package dice_pkg;

   typedef enum logic [1:0] {IDLE, SPIN, SETTLE, DONE} roll_state_t;

   typedef logic [2:0] face_t;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Maps any LFSR value onto a die face in 1..6.
   function automatic face_t face_of(input logic [7:0] l);
      return face_t'(l % 8'd6) + face_t'(1);
   endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that supplies die randomness.
// Advances every cycle out of reset; a zero seed is replaced so it can never lock up.
module dice_lfsr
   import dice_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] value
);

   localparam logic [7:0] SeedSafe = (SEED == 8'h00) ? 8'h01 : SEED;

   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= SeedSafe;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q;

endmodule

// File: rtl/dice_roll_sequencer.sv
// Roll-phase sequencer: spins the die face with a slowing animation, holds the final
// face, then pulses done for one cycle with the latched result.
module dice_roll_sequencer
   import dice_pkg::*;
#(
   parameter int unsigned SPIN_STEPS   = 12,
   parameter int unsigned BASE_DELAY   = 2,
   parameter int unsigned DELAY_GROWTH = 1,
   parameter int unsigned HOLD_CYCLES  = 8,
   parameter logic [7:0]  SEED         = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       abort_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [2:0] face_o,
   output logic [2:0] result_o
);

   localparam int unsigned CntW =
      $clog2(BASE_DELAY + SPIN_STEPS * DELAY_GROWTH + HOLD_CYCLES + 1);
   localparam int unsigned StepW = $clog2(SPIN_STEPS + 1);

   roll_state_t      state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [StepW-1:0] step_q, step_d;
   face_t            face_q, face_d;
   face_t            result_q, result_d;
   logic [7:0]       lfsr;

   dice_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .value (lfsr)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         step_q   <= '0;
         face_q   <= face_t'(1);
         result_q <= face_t'(1);
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         face_q   <= face_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_d   = step_q;
      face_d   = face_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               state_d = SPIN;
               step_d  = '0;
               cnt_d   = CntW'(BASE_DELAY - 1);
            end
         end
         SPIN: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               face_d = face_of(lfsr);
               step_d = step_q + 1'b1;
               // Each update waits one DELAY_GROWTH longer than the previous one.
               if (32'(step_q) == SPIN_STEPS - 1) begin
                  state_d = SETTLE;
                  cnt_d   = CntW'(HOLD_CYCLES - 1);
               end else begin
                  cnt_d = CntW'(BASE_DELAY + (32'(step_q) + 32'd1) * DELAY_GROWTH - 32'd1);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SETTLE: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d  = DONE;
               result_d = face_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o   = (state_q != IDLE);
   assign done_o   = (state_q == DONE);
   assign face_o   = face_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Scoreboard bench for dice_roll_sequencer with a short spin (4 steps, hold 2).
// Stimulus pushes expected done time and result; a negedge monitor pops and compares.
module tb_dice_roll_sequencer;

   localparam int S   = 4;
   localparam int B   = 1;
   localparam int G   = 1;
   localparam int H   = 2;
   localparam int T   = S * B + G * S * (S - 1) / 2;  // edge of the last face update
   localparam int LAT = 1 + T + H;                     // 13

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic       busy_o, done_o;
   logic [2:0] face_o, result_o;

   typedef struct {
      int cyc;
      int res;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   exp_t       dropped;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] m_lfsr;
   int         last_res = 1;
   int         seen[7];
   int         face_tab[13];
   int         r;
   bit         got;

   dice_roll_sequencer #(
      .SPIN_STEPS   (S),
      .BASE_DELAY   (B),
      .DELAY_GROWTH (G),
      .HOLD_CYCLES  (H),
      .SEED         (8'hA5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .abort_i  (abort_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .face_o   (face_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] nxt(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic int ref_face(input logic [7:0] l);
      return int'(l % 8'd6) + 1;
   endfunction

   // Result of a roll whose start is sampled while the LFSR holds l0.
   function automatic int ref_result(input logic [7:0] l0);
      logic [7:0] l;
      l = l0;
      for (int i = 0; i < T; i++) l = nxt(l);
      return ref_face(l);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue_start(input int res);
      exp_t e;
      e.cyc = cyc + LAT;
      e.res = res;
      sb.push_back(e);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done_o) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
      chk("done timeout", 0, 1);
   endtask

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      m_lfsr <= !rst_n ? 8'hA5 : nxt(m_lfsr);
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("lfsr model", int'(dut.lfsr), int'(m_lfsr));
         chk("lfsr nonzero", int'(dut.lfsr != 8'h00), 1);
         chk("face range", int'(face_o inside {[3'd1:3'd6]}), 1);
         if (done_o) begin
            if (sb.size() == 0) begin
               chk("unexpected done", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("done latency", cyc, mon_e.cyc);
               chk("roll result", int'(result_o), mon_e.res);
            end
         end
      end
   end

   initial begin
      face_tab = '{1, 3, 3, 1, 1, 1, 6, 6, 6, 6, 6, 6, 6};
      for (int f = 0; f < 7; f++) seen[f] = 0;

      // Reset held for two edges
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy", int'(busy_o), 0);
      chk("reset done", int'(done_o), 0);
      chk("reset face", int'(face_o), 1);
      chk("reset result", int'(result_o), 1);
      chk("reset lfsr", int'(dut.lfsr), 8'hA5);

      // Single roll from the seed: updates use A5 advanced 1,3,6,10 times -> 3,1,6,6
      rst_n = 1'b1;
      issue_start(6);
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge clk);
         chk("roll busy", int'(busy_o), 1);
         chk("spin face", int'(face_o), face_tab[k]);
      end
      @(negedge clk);
      chk("post busy", int'(busy_o), 0);
      chk("post done", int'(done_o), 0);
      last_res = 6;

      // Starts mid-SPIN and during DONE are dropped
      r = ref_result(m_lfsr);
      issue_start(r);
      repeat (3) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(got);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("ignored start busy", int'(busy_o), 0);
      @(negedge clk);
      chk("ignored start idle", int'(busy_o), 0);
      chk("ignored start result", int'(result_o), r);
      last_res = r;

      // Abort sampled on the fifth edge of a roll
      issue_start(ref_result(m_lfsr));
      repeat (4) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      dropped = sb.pop_back();
      chk("abort busy", int'(busy_o), 0);
      chk("abort done", int'(done_o), 0);
      chk("abort result", int'(result_o), last_res);
      repeat (20) @(negedge clk);
      chk("abort stays idle", int'(busy_o), 0);
      chk("abort result held", int'(result_o), last_res);

      // Abort and start together in IDLE
      start_i = 1'b1;
      abort_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      chk("abort beats start", int'(busy_o), 0);
      repeat (LAT + 2) @(negedge clk);

      // Reset asserted during SETTLE, then a fresh seed-based roll
      issue_start(ref_result(m_lfsr));
      repeat (10) @(negedge clk);
      chk("in settle busy", int'(busy_o), 1);
      rst_n = 1'b0;
      @(negedge clk);
      dropped = sb.pop_back();
      chk("mid reset busy", int'(busy_o), 0);
      chk("mid reset done", int'(done_o), 0);
      chk("mid reset face", int'(face_o), 1);
      chk("mid reset result", int'(result_o), 1);
      chk("mid reset lfsr", int'(dut.lfsr), 8'hA5);
      rst_n = 1'b1;
      issue_start(6);
      wait_done(got);
      @(negedge clk);
      chk("after reset roll idle", int'(busy_o), 0);

      // Back-to-back soak
      for (int n = 0; n < 2000; n++) begin
         issue_start(ref_result(m_lfsr));
         wait_done(got);
         if (!got) break;
         chk("soak result range", int'(result_o inside {[3'd1:3'd6]}), 1);
         seen[result_o] = 1;
         @(negedge clk);
      end
      for (int f = 1; f <= 6; f++) chk("face seen", seen[f], 1);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
